// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one OBI memory port between instruction fetch and data
module mem_port_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic [6:0]  instr_rdata_intg_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [6:0]  data_wdata_intg_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic [6:0]  data_rdata_intg_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [6:0]  mem_wdata_intg_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic [6:0]  mem_rdata_intg_i,
    input  logic        mem_err_i,

    output logic [2:0]  outstanding_o,
    output logic        protocol_err_o
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [2:0]    MAX_CNT    = 3'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [PW-1:0] PTR_LAST   = PW'(MAX_OUTSTANDING - 1);

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_e;

    state_e state_q;

    logic        held_sel_data_q;
    logic        held_we_q;
    logic [3:0]  held_be_q;
    logic [31:0] held_addr_q;
    logic [31:0] held_wdata_q;
    logic [6:0]  held_wdata_intg_q;

    logic [SW-1:0]              starve_q;
    logic [MAX_OUTSTANDING-1:0] src_fifo_q;
    logic [PW-1:0]              wr_ptr_q;
    logic [PW-1:0]              rd_ptr_q;
    logic [2:0]                 count_q;
    logic                       protocol_err_q;

    logic idle_sel_data;
    logic sel_data;
    logic any_req;
    logic slot_ok;
    logic grant;
    logic resp_valid;
    logic head_is_data;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    endfunction

    // Data normally wins; a fetch that has watched STARVE_LIMIT data grants goes first.
    always_comb begin
        idle_sel_data = 1'b0;
        if (data_req_i && instr_req_i) begin
            idle_sel_data = (starve_q != STARVE_MAX);
        end else if (data_req_i) begin
            idle_sel_data = 1'b1;
        end
    end

    assign sel_data = (state_q == ST_HOLD) ? held_sel_data_q : idle_sel_data;
    assign any_req  = (state_q == ST_HOLD) || instr_req_i || data_req_i;

    // A response arriving this cycle frees a slot for a new grant.
    assign slot_ok   = (count_q < MAX_CNT) || mem_rvalid_i;
    assign mem_req_o = !rst_i && any_req && slot_ok;
    assign grant     = mem_req_o && mem_gnt_i;

    always_comb begin
        mem_we_o         = 1'b0;
        mem_be_o         = 4'hF;
        mem_addr_o       = instr_addr_i;
        mem_wdata_o      = 32'h0;
        mem_wdata_intg_o = 7'h0;
        if (state_q == ST_HOLD) begin
            mem_we_o         = held_we_q;
            mem_be_o         = held_be_q;
            mem_addr_o       = held_addr_q;
            mem_wdata_o      = held_wdata_q;
            mem_wdata_intg_o = held_wdata_intg_q;
        end else if (idle_sel_data) begin
            mem_we_o         = data_we_i;
            mem_be_o         = data_be_i;
            mem_addr_o       = data_addr_i;
            mem_wdata_o      = data_wdata_i;
            mem_wdata_intg_o = data_wdata_intg_i;
        end
    end

    assign instr_gnt_o = grant && !sel_data;
    assign data_gnt_o  = grant && sel_data;

    // Responses with nothing outstanding are dropped here and flagged below.
    assign resp_valid   = !rst_i && mem_rvalid_i && (count_q != 3'd0);
    assign head_is_data = src_fifo_q[rd_ptr_q];

    assign instr_rvalid_o = resp_valid && !head_is_data;
    assign data_rvalid_o  = resp_valid && head_is_data;

    assign instr_rdata_o      = mem_rdata_i;
    assign instr_rdata_intg_o = mem_rdata_intg_i;
    assign instr_err_o        = mem_err_i;
    assign data_rdata_o       = mem_rdata_i;
    assign data_rdata_intg_o  = mem_rdata_intg_i;
    assign data_err_o         = mem_err_i;

    assign outstanding_o  = rst_i ? 3'd0 : count_q;
    assign protocol_err_o = protocol_err_q && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q           <= ST_IDLE;
            held_sel_data_q   <= 1'b0;
            held_we_q         <= 1'b0;
            held_be_q         <= 4'h0;
            held_addr_q       <= 32'h0;
            held_wdata_q      <= 32'h0;
            held_wdata_intg_q <= 7'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_req_o && !mem_gnt_i) begin
                        state_q           <= ST_HOLD;
                        held_sel_data_q   <= idle_sel_data;
                        held_we_q         <= mem_we_o;
                        held_be_q         <= mem_be_o;
                        held_addr_q       <= mem_addr_o;
                        held_wdata_q      <= mem_wdata_o;
                        held_wdata_intg_q <= mem_wdata_intg_o;
                    end
                end
                ST_HOLD: begin
                    if (grant) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else if (!instr_req_i || instr_gnt_o) begin
            starve_q <= '0;
        end else if (data_gnt_o && (starve_q != STARVE_MAX)) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_fifo_q     <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= 3'd0;
            protocol_err_q <= 1'b0;
        end else begin
            if (grant) begin
                src_fifo_q[wr_ptr_q] <= sel_data;
                wr_ptr_q             <= ptr_next(wr_ptr_q);
            end
            if (resp_valid) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            case ({grant, resp_valid})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
            if (mem_rvalid_i && (count_q == 3'd0)) begin
                protocol_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic [6:0]  instr_rdata_intg_o;
    logic        instr_err_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [6:0]  data_wdata_intg_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic [6:0]  data_rdata_intg_o;
    logic        data_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [6:0]  mem_wdata_intg_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [6:0]  mem_rdata_intg_i;
    logic        mem_err_i;
    logic [2:0]  outstanding_o;
    logic        protocol_err_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .instr_rdata_intg_o(instr_rdata_intg_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_wdata_intg_i(data_wdata_intg_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .data_rdata_intg_o(data_rdata_intg_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wdata_intg_o(mem_wdata_intg_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .mem_rdata_intg_i(mem_rdata_intg_i), .mem_err_i(mem_err_i),
        .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
    );

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic next_cycle();
        @(negedge clk_i);
    endtask

    task automatic quiet_inputs();
        instr_req_i = 1'b0; instr_addr_i = 32'h0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0; data_addr_i = 32'h0;
        data_wdata_i = 32'h0; data_wdata_intg_i = 7'h0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        mem_rdata_intg_i = 7'h0; mem_err_i = 1'b0;
    endtask

    task automatic test_reset();
        quiet_inputs();
        rst_i = 1'b1;
        instr_req_i = 1'b1; instr_addr_i = 32'h40;
        data_req_i = 1'b1; data_addr_i = 32'h44;
        mem_gnt_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            next_cycle(); #1;
            checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL reset_mem_req cyc=%0d got=%0h exp=0", c, mem_req_o); end
            checks++; if (instr_gnt_o !== 1'b0) begin failures++; $display("FAIL reset_instr_gnt cyc=%0d got=%0h exp=0", c, instr_gnt_o); end
            checks++; if (data_gnt_o !== 1'b0) begin failures++; $display("FAIL reset_data_gnt cyc=%0d got=%0h exp=0", c, data_gnt_o); end
            checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL reset_outstanding cyc=%0d got=%0d exp=0", c, outstanding_o); end
            checks++; if (protocol_err_o !== 1'b0) begin failures++; $display("FAIL reset_protocol_err cyc=%0d got=%0h exp=0", c, protocol_err_o); end
        end
        next_cycle();
        quiet_inputs();
        rst_i = 1'b0;
        #1;
        checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL post_reset_outstanding got=%0d exp=0", outstanding_o); end
    endtask

    task automatic test_single_fetch();
        next_cycle(); quiet_inputs();
        instr_req_i = 1'b1; instr_addr_i = 32'h80; mem_gnt_i = 1'b1;
        #1;
        checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL fetch_mem_req got=%0h exp=1", mem_req_o); end
        checks++; if (mem_addr_o !== 32'h80) begin failures++; $display("FAIL fetch_addr got=%h exp=00000080", mem_addr_o); end
        checks++; if (mem_be_o !== 4'hF) begin failures++; $display("FAIL fetch_be got=%h exp=f", mem_be_o); end
        checks++; if (mem_we_o !== 1'b0) begin failures++; $display("FAIL fetch_we got=%0h exp=0", mem_we_o); end
        checks++; if (mem_wdata_o !== 32'h0) begin failures++; $display("FAIL fetch_wdata got=%h exp=0", mem_wdata_o); end
        checks++; if (instr_gnt_o !== 1'b1) begin failures++; $display("FAIL fetch_instr_gnt got=%0h exp=1", instr_gnt_o); end
        checks++; if (data_gnt_o !== 1'b0) begin failures++; $display("FAIL fetch_data_gnt got=%0h exp=0", data_gnt_o); end
        next_cycle(); quiet_inputs();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h13; mem_rdata_intg_i = 7'h2A;
        #1;
        checks++; if (outstanding_o !== 3'd1) begin failures++; $display("FAIL fetch_outstanding got=%0d exp=1", outstanding_o); end
        checks++; if (instr_rvalid_o !== 1'b1) begin failures++; $display("FAIL fetch_instr_rvalid got=%0h exp=1", instr_rvalid_o); end
        checks++; if (instr_rdata_o !== 32'h13) begin failures++; $display("FAIL fetch_rdata got=%h exp=00000013", instr_rdata_o); end
        checks++; if (instr_rdata_intg_o !== 7'h2A) begin failures++; $display("FAIL fetch_rdata_intg got=%h exp=2a", instr_rdata_intg_o); end
        checks++; if (data_rvalid_o !== 1'b0) begin failures++; $display("FAIL fetch_data_rvalid got=%0h exp=0", data_rvalid_o); end
        next_cycle(); quiet_inputs(); #1;
        checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL fetch_drained got=%0d exp=0", outstanding_o); end
    endtask

    task automatic test_simultaneous();
        next_cycle(); quiet_inputs();
        instr_req_i = 1'b1; instr_addr_i = 32'h84;
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'h3; data_addr_i = 32'h100;
        data_wdata_i = 32'hDEADBEEF; data_wdata_intg_i = 7'h55; mem_gnt_i = 1'b1;
        #1;
        checks++; if (data_gnt_o !== 1'b1) begin failures++; $display("FAIL simul_c0_data_gnt got=%0h exp=1", data_gnt_o); end
        checks++; if (instr_gnt_o !== 1'b0) begin failures++; $display("FAIL simul_c0_instr_gnt got=%0h exp=0", instr_gnt_o); end
        checks++; if ({mem_addr_o, mem_be_o, mem_we_o} !== {32'h100, 4'h3, 1'b1}) begin failures++; $display("FAIL simul_c0_fields got=%h/%h/%0h exp=00000100/3/1", mem_addr_o, mem_be_o, mem_we_o); end
        checks++; if ({mem_wdata_o, mem_wdata_intg_o} !== {32'hDEADBEEF, 7'h55}) begin failures++; $display("FAIL simul_c0_wdata got=%h/%h exp=deadbeef/55", mem_wdata_o, mem_wdata_intg_o); end
        next_cycle();
        data_req_i = 1'b0;
        #1;
        checks++; if (instr_gnt_o !== 1'b1) begin failures++; $display("FAIL simul_c1_instr_gnt got=%0h exp=1", instr_gnt_o); end
        checks++; if ({mem_addr_o, mem_be_o, mem_we_o} !== {32'h84, 4'hF, 1'b0}) begin failures++; $display("FAIL simul_c1_fields got=%h/%h/%0h exp=00000084/f/0", mem_addr_o, mem_be_o, mem_we_o); end
        next_cycle(); quiet_inputs();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA5A5A5A5;
        #1;
        checks++; if (outstanding_o !== 3'd2) begin failures++; $display("FAIL simul_outstanding got=%0d exp=2", outstanding_o); end
        checks++; if ({data_rvalid_o, instr_rvalid_o} !== 2'b10) begin failures++; $display("FAIL simul_resp0_route got=d%0h/i%0h exp=d1/i0", data_rvalid_o, instr_rvalid_o); end
        checks++; if (data_rdata_o !== 32'hA5A5A5A5) begin failures++; $display("FAIL simul_resp0_rdata got=%h exp=a5a5a5a5", data_rdata_o); end
        next_cycle();
        mem_rdata_i = 32'h00000013;
        #1;
        checks++; if ({data_rvalid_o, instr_rvalid_o} !== 2'b01) begin failures++; $display("FAIL simul_resp1_route got=d%0h/i%0h exp=d0/i1", data_rvalid_o, instr_rvalid_o); end
        next_cycle(); quiet_inputs(); #1;
        checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL simul_drained got=%0d exp=0", outstanding_o); end
    endtask

    task automatic test_hold();
        next_cycle(); quiet_inputs();
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'h3; data_addr_i = 32'h100;
        data_wdata_i = 32'h12345678; data_wdata_intg_i = 7'h11;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                instr_req_i = 1'b1; instr_addr_i = 32'h88;
                // The data side changing its fields must not disturb a held request.
                data_addr_i = 32'h200; data_be_i = 4'hC; data_wdata_i = 32'h0;
            end
            #1;
            checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL hold_mem_req cyc=%0d got=%0h exp=1", c, mem_req_o); end
            checks++; if ({mem_addr_o, mem_be_o, mem_we_o} !== {32'h100, 4'h3, 1'b1}) begin failures++; $display("FAIL hold_fields cyc=%0d got=%h/%h/%0h exp=00000100/3/1", c, mem_addr_o, mem_be_o, mem_we_o); end
            checks++; if (mem_wdata_o !== 32'h12345678) begin failures++; $display("FAIL hold_wdata cyc=%0d got=%h exp=12345678", c, mem_wdata_o); end
            checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b00) begin failures++; $display("FAIL hold_no_gnt cyc=%0d got=i%0h/d%0h exp=i0/d0", c, instr_gnt_o, data_gnt_o); end
            next_cycle();
        end
        mem_gnt_i = 1'b1;
        #1;
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin failures++; $display("FAIL hold_release_gnt got=i%0h/d%0h exp=i0/d1", instr_gnt_o, data_gnt_o); end
        checks++; if (mem_addr_o !== 32'h100) begin failures++; $display("FAIL hold_release_addr got=%h exp=00000100", mem_addr_o); end
        next_cycle();
        data_req_i = 1'b0;
        #1;
        checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin failures++; $display("FAIL hold_fetch_gnt got=i%0h/d%0h exp=i1/d0", instr_gnt_o, data_gnt_o); end
        checks++; if (mem_addr_o !== 32'h88) begin failures++; $display("FAIL hold_fetch_addr got=%h exp=00000088", mem_addr_o); end
        next_cycle(); quiet_inputs(); mem_rvalid_i = 1'b1; #1;
        checks++; if (data_rvalid_o !== 1'b1) begin failures++; $display("FAIL hold_resp_data got=%0h exp=1", data_rvalid_o); end
        next_cycle(); #1;
        checks++; if (instr_rvalid_o !== 1'b1) begin failures++; $display("FAIL hold_resp_instr got=%0h exp=1", instr_rvalid_o); end
        next_cycle(); quiet_inputs(); #1;
        checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL hold_drained got=%0d exp=0", outstanding_o); end
    endtask

    task automatic test_starvation();
        logic exp_i;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            instr_req_i = 1'b1; instr_addr_i = 32'h90;
            data_req_i = 1'b1; data_addr_i = 32'h300; data_be_i = 4'hF;
            mem_gnt_i = 1'b1; mem_rvalid_i = (c > 0);
            exp_i = ((c % 5) == 4);
            #1;
            checks++; if ({instr_gnt_o, data_gnt_o} !== {exp_i, ~exp_i}) begin failures++; $display("FAIL starve_pattern cyc=%0d got=i%0h/d%0h exp=i%0h/d%0h", c, instr_gnt_o, data_gnt_o, exp_i, ~exp_i); end
        end
        next_cycle(); quiet_inputs(); mem_rvalid_i = 1'b1; #1;
        checks++; if (outstanding_o !== 3'd1) begin failures++; $display("FAIL starve_outstanding got=%0d exp=1", outstanding_o); end
        next_cycle(); quiet_inputs(); #1;
        checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL starve_drained got=%0d exp=0", outstanding_o); end
        checks++; if (protocol_err_o !== 1'b0) begin failures++; $display("FAIL starve_protocol_err got=%0h exp=0", protocol_err_o); end
    endtask

    task automatic test_outstanding_limit();
        for (int c = 0; c < 4; c++) begin
            next_cycle(); quiet_inputs();
            instr_req_i = 1'b1; instr_addr_i = 32'hA0; mem_gnt_i = 1'b1;
            #1;
            checks++; if (instr_gnt_o !== (c < 2)) begin failures++; $display("FAIL limit_gnt cyc=%0d got=%0h exp=%0h", c, instr_gnt_o, (c < 2)); end
            checks++; if (outstanding_o !== ((c < 2) ? 3'(c) : 3'd2)) begin failures++; $display("FAIL limit_outstanding cyc=%0d got=%0d", c, outstanding_o); end
        end
        checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL limit_mem_req got=%0h exp=0", mem_req_o); end
        next_cycle();
        mem_rvalid_i = 1'b1;
        #1;
        checks++; if ({mem_req_o, instr_gnt_o, instr_rvalid_o} !== 3'b111) begin failures++; $display("FAIL limit_slot_freed got=req%0h/gnt%0h/rv%0h exp=1/1/1", mem_req_o, instr_gnt_o, instr_rvalid_o); end
        next_cycle(); instr_req_i = 1'b0; mem_gnt_i = 1'b0; #1;
        checks++; if (outstanding_o !== 3'd2) begin failures++; $display("FAIL limit_swap_count got=%0d exp=2", outstanding_o); end
        next_cycle(); #1;
        checks++; if (outstanding_o !== 3'd1) begin failures++; $display("FAIL limit_pop_count got=%0d exp=1", outstanding_o); end
        next_cycle(); #1;
        checks++; if ({outstanding_o, protocol_err_o} !== {3'd0, 1'b0}) begin failures++; $display("FAIL limit_empty got=%0d/%0h exp=0/0", outstanding_o, protocol_err_o); end
        checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin failures++; $display("FAIL unexpected_dropped got=i%0h/d%0h exp=i0/d0", instr_rvalid_o, data_rvalid_o); end
        for (int c = 0; c < 3; c++) begin
            next_cycle(); quiet_inputs(); #1;
            checks++; if (protocol_err_o !== 1'b1) begin failures++; $display("FAIL protocol_err_sticky cyc=%0d got=%0h exp=1", c, protocol_err_o); end
            checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL no_underflow cyc=%0d got=%0d exp=0", c, outstanding_o); end
        end
    endtask

    task automatic test_reset_midflight();
        next_cycle(); quiet_inputs();
        instr_req_i = 1'b1; instr_addr_i = 32'hB0; mem_gnt_i = 1'b1;
        next_cycle(); quiet_inputs(); rst_i = 1'b1;
        next_cycle(); rst_i = 1'b0; #1;
        checks++; if ({outstanding_o, protocol_err_o} !== {3'd0, 1'b0}) begin failures++; $display("FAIL midreset_cleared got=%0d/%0h exp=0/0", outstanding_o, protocol_err_o); end
        next_cycle(); mem_rvalid_i = 1'b1; #1;
        checks++; if (instr_rvalid_o !== 1'b0) begin failures++; $display("FAIL midreset_stale_rvalid got=%0h exp=0", instr_rvalid_o); end
        next_cycle(); quiet_inputs(); #1;
        checks++; if (protocol_err_o !== 1'b1) begin failures++; $display("FAIL midreset_protocol_err got=%0h exp=1", protocol_err_o); end
    endtask

    initial begin
        rst_i = 1'b1;
        quiet_inputs();
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_hold();
        test_starvation();
        test_outstanding_limit();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
